// File: rtl/sha3_pkg.sv
// Shared types and constants for the SHA3 digest unpacker.
// Rates are in bits; the chunk width matches the largest rate.
package sha3_pkg;

  localparam int RATE_SHA3_224 = 1152;
  localparam int RATE_SHA3_256 = 1088;
  localparam int RATE_SHA3_384 = 832;
  localparam int RATE_SHA3_512 = 576;
  localparam int RATE_SHAKE128 = 1344;

  localparam int CHUNK_W = RATE_SHAKE128;
  localparam int LEN_W   = 11;
  localparam int DEPTH   = 2;
  localparam int LB_W    = 8;

  typedef enum logic [1:0] {
    MODE_SHA3_224 = 2'd0,
    MODE_SHA3_256 = 2'd1,
    MODE_SHA3_384 = 2'd2,
    MODE_SHA3_512 = 2'd3
  } mode_e;

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } rd_state_e;

  typedef struct packed {
    logic [CHUNK_W-1:0] data;
    logic [LB_W-1:0]    len_bytes;
    mode_e              mode;
    logic               last;
  } chunk_t;

  function automatic logic len_ok(
    input logic [LEN_W-1:0] len
  );
    return (len != '0)
        && (len <= LEN_W'(CHUNK_W))
        && (len[2:0] == 3'd0);
  endfunction

endpackage

// File: rtl/sha3_digest_unpacker_if.sv
// Digest chunk input plus byte-stream output bundle.
// The core side has no backpressure; the byte side is valid/ready.
interface sha3_digest_unpacker_if;
  import sha3_pkg::*;

  logic               in_valid;
  logic [CHUNK_W-1:0] in_data;
  logic [LEN_W-1:0]   in_length;
  logic [1:0]         in_mode;
  logic               in_finish;
  logic [7:0]         out_byte;
  logic               out_valid;
  logic               out_ready;
  logic               out_last;
  logic [1:0]         out_mode;
  logic               done;
  logic               overflow;
  logic               len_err;

  modport slave (
    input  in_valid, in_data, in_length,
    input  in_mode, in_finish, out_ready,
    output out_byte, out_valid, out_last,
    output out_mode, done, overflow, len_err
  );

  modport master (
    output in_valid, in_data, in_length,
    output in_mode, in_finish, out_ready,
    input  out_byte, out_valid, out_last,
    input  out_mode, done, overflow, len_err
  );

endinterface

// File: rtl/sha3_chunk_buf.sv
// Two-entry chunk store with occupied bits and 1-bit pointers.
// A pop and a write to the same entry in one cycle leave it occupied.
module sha3_chunk_buf
  import sha3_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   i_wr,
  input  chunk_t i_wr_ent,
  input  logic   i_pop,
  output logic   o_wr_busy,
  output logic   o_rd_occ,
  output logic   o_nxt_occ,
  output chunk_t o_rd_ent
);

  logic [DEPTH-1:0] r_occ;
  chunk_t           r_ent [DEPTH];
  logic             r_wptr;
  logic             r_rptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_occ    <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_ent[0] <= '0;
      r_ent[1] <= '0;
    end else begin
      if (i_pop) begin
        r_occ[r_rptr] <= 1'b0;
        r_rptr        <= ~r_rptr;
      end
      if (i_wr) begin
        r_occ[r_wptr] <= 1'b1;
        r_ent[r_wptr] <= i_wr_ent;
        r_wptr        <= ~r_wptr;
      end
    end
  end

  assign o_wr_busy = r_occ[r_wptr]
                   & ~(i_pop & (r_rptr == r_wptr));
  assign o_rd_occ  = r_occ[r_rptr];
  assign o_nxt_occ = r_occ[~r_rptr];
  assign o_rd_ent  = r_ent[r_rptr];

endmodule

// File: rtl/sha3_digest_unpacker.sv
// Buffers SHA3 digest chunks and streams them out MSB-first as bytes.
// Chunks that cannot be stored are dropped and flagged, never stalled.
module sha3_digest_unpacker
  import sha3_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  sha3_digest_unpacker_if.slave io
);

  rd_state_e       r_state;
  rd_state_e       w_nxt;
  logic [LB_W-1:0] r_idx;
  logic            r_done;
  logic            r_ovf;
  logic            r_lerr;

  chunk_t          w_wr_ent;
  chunk_t          w_rd;
  logic            w_legal;
  logic            w_busy;
  logic            w_wr;
  logic            w_rd_occ;
  logic            w_nxt_occ;
  logic            w_send;
  logic            w_fire;
  logic            w_final;
  logic            w_pop;
  logic [LB_W-1:0] w_bidx;

  assign w_legal  = len_ok(io.in_length);
  assign w_wr     = io.in_valid & w_legal & ~w_busy;
  assign w_wr_ent = '{
    data:      io.in_data,
    len_bytes: io.in_length[LEN_W-1:3],
    mode:      mode_e'(io.in_mode),
    last:      io.in_finish
  };

  sha3_chunk_buf u_buf (
    .clk       (clk),
    .rst       (rst),
    .i_wr      (w_wr),
    .i_wr_ent  (w_wr_ent),
    .i_pop     (w_pop),
    .o_wr_busy (w_busy),
    .o_rd_occ  (w_rd_occ),
    .o_nxt_occ (w_nxt_occ),
    .o_rd_ent  (w_rd)
  );

  assign w_send  = (r_state == ST_SEND);
  assign w_fire  = w_send & io.out_ready;
  assign w_final = (r_idx == w_rd.len_bytes - LB_W'(1));
  assign w_pop   = w_fire & w_final;
  assign w_bidx  = w_rd.len_bytes - r_idx - LB_W'(1);

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (w_rd_occ) w_nxt = ST_SEND;
      ST_SEND: if (w_pop && !w_nxt_occ) w_nxt = ST_IDLE;
      default: w_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
      r_lerr  <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_done  <= w_pop & w_rd.last;
      if (w_pop)       r_idx <= '0;
      else if (w_fire) r_idx <= r_idx + LB_W'(1);
      if (io.in_valid & ~w_legal)         r_lerr <= 1'b1;
      if (io.in_valid & w_legal & w_busy) r_ovf  <= 1'b1;
    end
  end

  assign io.out_valid = w_send;
  assign io.out_byte  = w_send ? w_rd.data[{w_bidx, 3'b000} +: 8] : 8'd0;
  assign io.out_last  = w_send & w_rd.last & w_final;
  assign io.out_mode  = w_send ? w_rd.mode : 2'd0;
  assign io.done      = r_done;
  assign io.overflow  = r_ovf;
  assign io.len_err   = r_lerr;

endmodule
